// File: rtl/uart_tx_controller.sv
// -----------------------------------------------------------------------------
// uart_tx_controller
//
// Frame sequencer for the UART transmit path. It accepts a parallel word from
// the host, tells the serializer when to capture it and when to shift, works
// out the parity bit, and steers the TX output mux through the start, data,
// parity and stop bits, one bit per clock.
//
// Ports:
//   uart_tx_controller_CLK      bit-rate clock, one serial bit per cycle
//   uart_tx_controller_RST_ASYN asynchronous active-low reset
//   P_DATA      [DATA_WIDTH]    parallel word, valid while DATA_VALID=1
//   DATA_VALID                  request to transmit P_DATA
//   PAR_EN                      1 = insert a parity bit after the data
//   PAR_TYP                     0 = even parity, 1 = odd parity
//   ser_done                    serializer counter is at all-ones
//   ser_load                    serializer captures P_DATA on the next edge
//   ser_en                      serializer shift and counter enable
//   mux_sel     [2]             00 start, 01 stop/idle, 10 data, 11 parity
//   par_bit                     parity bit of the frame being sent
//   busy                        high while a frame is in progress
//
// Optional build macro:
//   UART_TX_CTRL_TWO_STOP_EN    adds a second stop bit (state ST_STOP2); the
//                               back-to-back acceptance point moves from the
//                               first to the second stop bit.
// -----------------------------------------------------------------------------
module uart_tx_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                  uart_tx_controller_CLK,
   input  logic                  uart_tx_controller_RST_ASYN,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  ser_done,
   output logic                  ser_load,
   output logic                  ser_en,
   output logic [1:0]            mux_sel,
   output logic                  par_bit,
   output logic                  busy
);

   // The serializer counts DATA_WIDTH bits with a CNT_WIDTH-bit counter and
   // flags ser_done at all-ones, so the two widths have to agree.
   if ((2 ** CNT_WIDTH) != DATA_WIDTH) begin : g_cfg_check
      $error("uart_tx_controller: 2**CNT_WIDTH must equal DATA_WIDTH");
   end

   localparam logic [1:0] MUX_START  = 2'b00;
   localparam logic [1:0] MUX_STOP   = 2'b01;
   localparam logic [1:0] MUX_DATA   = 2'b10;
   localparam logic [1:0] MUX_PARITY = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
`ifdef UART_TX_CTRL_TWO_STOP_EN
      , ST_STOP2
`endif
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   par_en_q;
   logic   par_en_d;
   logic   par_bit_q;
   logic   par_bit_d;
   logic   load_req;

   // State and frame-configuration registers. The parity enable and the
   // parity bit are captured only when a word is accepted, so host-side
   // changes mid-frame never disturb the frame on the wire.
   always_ff @(posedge uart_tx_controller_CLK or negedge uart_tx_controller_RST_ASYN) begin
      if (!uart_tx_controller_RST_ASYN) begin
         state_q   <= ST_IDLE;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
      end
   end

   // Next-state logic. A word is accepted either from IDLE or from the final
   // stop bit; accepting from the stop bit lets frames run back to back with
   // no idle-high gap. DATA_VALID anywhere else is simply dropped.
   always_comb begin
      state_d   = state_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      load_req  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (DATA_VALID) begin
               load_req = 1'b1;
               state_d  = ST_START;
            end
         end

         ST_START: begin
            state_d = ST_DATA;
         end

         // ser_done is high in the cycle that carries the last data bit.
         ST_DATA: begin
            if (ser_done) begin
               state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
         end

         ST_PARITY: begin
            state_d = ST_STOP;
         end

`ifdef UART_TX_CTRL_TWO_STOP_EN
         ST_STOP: begin
            state_d = ST_STOP2;
         end

         ST_STOP2: begin
            if (DATA_VALID) begin
               load_req = 1'b1;
               state_d  = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
`else
         ST_STOP: begin
            if (DATA_VALID) begin
               load_req = 1'b1;
               state_d  = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Even parity is the XOR of all data bits; inverting it gives odd.
      if (load_req) begin
         par_en_d  = PAR_EN;
         par_bit_d = (^P_DATA) ^ PAR_TYP;
      end
   end

   // Moore output decode. Only the data state enables the serializer, so its
   // counter is held at zero in every other state and starts each frame clean.
   always_comb begin
      mux_sel = MUX_STOP;
      busy    = 1'b1;
      ser_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
         end

         ST_START: begin
            mux_sel = MUX_START;
         end

         ST_DATA: begin
            mux_sel = MUX_DATA;
            ser_en  = 1'b1;
         end

         ST_PARITY: begin
            mux_sel = MUX_PARITY;
         end

         default: begin
            mux_sel = MUX_STOP;
         end
      endcase
   end

   // ser_load is the one Mealy output. It is qualified with the reset so that
   // a DATA_VALID held high during reset cannot make the serializer load.
   assign ser_load = load_req & uart_tx_controller_RST_ASYN;
   assign par_bit  = par_bit_q;

endmodule
